// File: rtl/lcd_char_pkg.sv
// Shared constants and FSM state type for the LCD character path.
package lcd_char_pkg;
    localparam int ASCII_W      = 7;
    localparam int COORD_W      = 9;
    localparam int ASCII_OFFSET = 32;

    localparam logic FONT_16X8 = 1'b1;
    localparam logic FONT_12X6 = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;
endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin select: first set req bit scanning upward from ptr+1 with wrap.
module lcd_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_idx,
    output logic               gnt_valid
);
    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx[1:0];
            end
        end
        gnt_valid = found;
    end
endmodule

// File: rtl/lcd_char_arbiter.sv
// Round-robin sharing of the LCD char-render engine between NUM_REQ string controllers.
// Optional engine watchdog enabled by defining LCD_CHAR_ARB_TIMEOUT_EN.
module lcd_char_arbiter
    import lcd_char_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         init_done,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [ASCII_W*NUM_REQ-1:0]   req_ascii,
    input  logic [COORD_W*NUM_REQ-1:0]   req_x,
    input  logic [COORD_W*NUM_REQ-1:0]   req_y,
    input  logic [NUM_REQ-1:0]           req_size,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         show_char_done,
    output logic                         show_char_flag,
    output logic [ASCII_W-1:0]           ascii_num,
    output logic [COORD_W-1:0]           start_x,
    output logic [COORD_W-1:0]           start_y,
    output logic                         en_size,
    output logic                         busy,
    output logic [1:0]                   grant_id,
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    output logic [1:0]                   state_dbg
);
    // Handshake: req[i] is a level "valid" with its data held stable while high;
    // ack[i] is a one-cycle "ready/complete" pulse. On the edge a requester samples
    // ack[i]=1 it either drops req[i] or presents its next job.

    arb_state_t           state, state_nx;
    logic [1:0]           ptr, ptr_nx, grant_id_nx;
    logic [NUM_REQ-1:0]   gnt_oh, ack_nx;
    logic [1:0]           gnt_idx;
    logic                 gnt_valid;
    logic [ASCII_W-1:0]   ascii_nx;
    logic [COORD_W-1:0]   x_nx, y_nx;
    logic                 size_nx, flag_nx;
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
    logic [15:0]          cnt, cnt_nx;
    logic                 tmo_nx;
`endif

    lcd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req),
        .ptr       (ptr),
        .gnt       (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        grant_id_nx = grant_id;
        ascii_nx    = ascii_num;
        x_nx        = start_x;
        y_nx        = start_y;
        size_nx     = en_size;
        flag_nx     = 1'b0;
        ack_nx      = '0;
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
        cnt_nx      = cnt;
        tmo_nx      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (init_done && gnt_valid) begin
                    state_nx    = ISSUE;
                    grant_id_nx = gnt_idx;
                    ascii_nx    = req_ascii[int'(gnt_idx)*ASCII_W +: ASCII_W];
                    x_nx        = req_x[int'(gnt_idx)*COORD_W +: COORD_W];
                    y_nx        = req_y[int'(gnt_idx)*COORD_W +: COORD_W];
                    size_nx     = req_size[gnt_idx];
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                flag_nx  = 1'b1;
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            WAIT: begin
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
                if (show_char_done) begin
                    state_nx = ACK;
                end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
                    state_nx = ACK;
                    tmo_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
`else
                if (show_char_done) begin
                    state_nx = ACK;
                end
`endif
            end
            ACK: begin
                ptr_nx   = grant_id;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Losing init mid-job abandons the job silently; pointer keeps its old value.
        if (state != IDLE && !init_done) begin
            state_nx = IDLE;
            ptr_nx   = ptr;
            ascii_nx = '0;
            x_nx     = '0;
            y_nx     = '0;
            size_nx  = 1'b0;
            flag_nx  = 1'b0;
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
            tmo_nx   = 1'b0;
`endif
        end

        if (state_nx == ACK) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ack_nx[i] = (grant_id == 2'(i));
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= IDLE;
            ptr            <= 2'(NUM_REQ - 1);
            grant_id       <= '0;
            ascii_num      <= '0;
            start_x        <= '0;
            start_y        <= '0;
            en_size        <= 1'b0;
            show_char_flag <= 1'b0;
            ack            <= '0;
            busy           <= 1'b0;
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
            cnt            <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            state          <= state_nx;
            ptr            <= ptr_nx;
            grant_id       <= grant_id_nx;
            ascii_num      <= ascii_nx;
            start_x        <= x_nx;
            start_y        <= y_nx;
            en_size        <= size_nx;
            show_char_flag <= flag_nx;
            ack            <= ack_nx;
            busy           <= (state_nx != IDLE);
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
            cnt            <= cnt_nx;
            timeout_err    <= tmo_nx;
`endif
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Directed self-checking bench for lcd_char_arbiter (NUM_REQ = 2).
// Define LCD_CHAR_ARB_TIMEOUT_EN to add the watchdog scenario.
module tb_lcd_char_arbiter;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        init_done = 1'b0;
    logic [1:0]  req = '0;
    logic [13:0] req_ascii = '0;
    logic [17:0] req_x = '0;
    logic [17:0] req_y = '0;
    logic [1:0]  req_size = '0;
    logic [1:0]  ack;
    logic        show_char_done = 1'b0;
    logic        show_char_flag;
    logic [6:0]  ascii_num;
    logic [8:0]  start_x, start_y;
    logic        en_size, busy;
    logic [1:0]  grant_id, state_dbg;
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    // Per-requester job data as seen by the bench.
    logic [6:0] job_ascii [2] = '{7'd40, 7'd33};
    logic [8:0] job_x     [2] = '{9'd128, 9'd200};
    logic [8:0] job_y     [2] = '{9'd16, 9'd100};
    logic       job_size  [2] = '{1'b1, 1'b0};

    lcd_char_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(20)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .init_done      (init_done),
        .req            (req),
        .req_ascii      (req_ascii),
        .req_x          (req_x),
        .req_y          (req_y),
        .req_size       (req_size),
        .ack            (ack),
        .show_char_done (show_char_done),
        .show_char_flag (show_char_flag),
        .ascii_num      (ascii_num),
        .start_x        (start_x),
        .start_y        (start_y),
        .en_size        (en_size),
        .busy           (busy),
        .grant_id       (grant_id),
`ifdef LCD_CHAR_ARB_TIMEOUT_EN
        .timeout_err    (timeout_err),
`endif
        .state_dbg      (state_dbg)
    );

    // Clock / reset
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic wait_flag(input int max_cyc);
        int n;
        n = 0;
        while (show_char_flag !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("flag_seen", 32'(show_char_flag), 32'd1);
    endtask

    task automatic pulse_done();
        show_char_done = 1'b1;
        tick();
        show_char_done = 1'b0;
    endtask

    task automatic check_job(input int id);
        chk("ascii_num", 32'(ascii_num), 32'(job_ascii[id]));
        chk("start_x",   32'(start_x),   32'(job_x[id]));
        chk("start_y",   32'(start_y),   32'(job_y[id]));
        chk("en_size",   32'(en_size),   32'(job_size[id]));
    endtask

    initial begin
        int flags;
        logic [1:0] e;
        req_ascii = {job_ascii[1], job_ascii[0]};
        req_x     = {job_x[1], job_x[0]};
        req_y     = {job_y[1], job_y[0]};
        req_size  = {job_size[1], job_size[0]};

        // 1. reset state and single job latency
        do_reset();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_flag",  32'(show_char_flag), 32'd0);
        chk("rst_ack",   32'(ack), 32'd0);
        chk("rst_gid",   32'(grant_id), 32'd0);
        chk("rst_ascii", 32'(ascii_num), 32'd0);
        chk("rst_x",     32'(start_x), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        init_done = 1'b1;
        req = 2'b01;
        tick();
        chk("t1_issue_state", 32'(state_dbg), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_flag_early", 32'(show_char_flag), 32'd0);
        tick();
        chk("t1_flag", 32'(show_char_flag), 32'd1);
        check_job(0);
        repeat (9) begin
            tick();
            chk("t1_wait_flag", 32'(show_char_flag), 32'd0);
        end
        chk("t1_no_ack", 32'(ack), 32'd0);
        pulse_done();
        chk("t1_ack", 32'(ack), 32'b01);
        check_job(0);
        req = 2'b00;
        tick();
        chk("t1_ack_gone", 32'(ack), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2. round-robin with both requesters held active
        do_reset();
        init_done = 1'b1;
        req = 2'b11;
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_flag(10);
            chk("t2_gid", 32'(grant_id), 32'(e));
            check_job(int'(e));
            tick();
            tick();
            pulse_done();
            chk("t2_ack", 32'(ack), 32'(2'b01 << e));
        end
        req = 2'b00;
        tick();

        // 3. no grant while init_done is low
        do_reset();
        init_done = 1'b0;
        req = 2'b01;
        flags = 0;
        repeat (50) begin
            tick();
            if (show_char_flag) flags++;
        end
        chk("t3_no_flag", 32'(flags), 32'd0);
        chk("t3_no_busy", 32'(busy), 32'd0);
        init_done = 1'b1;
        tick();
        chk("t3_flag_early", 32'(show_char_flag), 32'd0);
        tick();
        chk("t3_flag", 32'(show_char_flag), 32'd1);
        tick();
        pulse_done();
        chk("t3_ack", 32'(ack), 32'b01);
        req = 2'b00;
        tick();

        // 4. abort in WAIT; pointer left at 0 so requester 1 is regranted
        req = 2'b11;
        wait_flag(10);
        chk("t4_gid", 32'(grant_id), 32'd1);
        tick();
        chk("t4_wait", 32'(state_dbg), 32'd2);
        init_done = 1'b0;
        tick();
        chk("t4_state", 32'(state_dbg), 32'd0);
        chk("t4_no_ack", 32'(ack), 32'd0);
        chk("t4_ascii0", 32'(ascii_num), 32'd0);
        chk("t4_x0", 32'(start_x), 32'd0);
        chk("t4_y0", 32'(start_y), 32'd0);
        chk("t4_size0", 32'(en_size), 32'd0);
        chk("t4_busy0", 32'(busy), 32'd0);
        init_done = 1'b1;
        wait_flag(10);
        chk("t4_regrant", 32'(grant_id), 32'd1);
        check_job(1);
        // dropping req after grant still completes the job
        req = 2'b00;
        tick();
        pulse_done();
        chk("t4_ack", 32'(ack), 32'b10);
        tick();

        // 6. done pulse in IDLE is ignored
        pulse_done();
        chk("t6_no_ack", 32'(ack), 32'd0);
        chk("t6_state", 32'(state_dbg), 32'd0);
        tick();
        chk("t6_no_ack2", 32'(ack), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

`ifdef LCD_CHAR_ARB_TIMEOUT_EN
        // 5. watchdog fires 20 cycles after WAIT entry
        begin
            int n;
            req = 2'b01;
            wait_flag(10);
            req = 2'b00;
            n = 0;
            while (ack == 2'b00 && n < 40) begin
                tick();
                n++;
            end
            chk("t5_tmo_cycles", 32'(n), 32'd20);
            chk("t5_tmo_ack", 32'(ack), 32'b01);
            chk("t5_tmo_err", 32'(timeout_err), 32'd1);
            tick();
            chk("t5_tmo_err_clr", 32'(timeout_err), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_char_arbiter.md
Name: lcd_char_arbiter

Overview:
- Shares the single LCD character-render engine (show_char path: show_char_flag / ascii_num / start_x / start_y / en_size in, show_char_done out) between NUM_REQ independent string controllers.
- Each requester submits one character job at a time.
- The block arbitrates round-robin, issues the start pulse to the engine, waits for completion, and acknowledges the winner.
- Sits between the string/number controllers and the char-render engine, above the LCD init/write layer.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYC, 65535, engine watchdog limit in sys_clk cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  reset, synchronous, active-high.
- init_done  in  1  LCD init complete; no job is granted while low.
- req  in  NUM_REQ  per-requester job request, level.
- req_ascii  in  7*NUM_REQ  packed glyph index (ASCII-32), slice i = requester i.
- req_x  in  9*NUM_REQ  packed start column.
- req_y  in  9*NUM_REQ  packed start row.
- req_size  in  NUM_REQ  per-requester font select (1 = 16x8, 0 = 12x6).
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- show_char_done  in  1  engine completion pulse.
- show_char_flag  out  1  one-cycle engine start pulse.
- ascii_num  out  7  latched glyph index to engine.
- start_x  out  9  latched column to engine.
- start_y  out  9  latched row to engine.
- en_size  out  1  latched font select to engine.
- busy  out  1  high in any state except IDLE.
- grant_id  out  2  index of current or last granted requester.

Behaviour:
- All outputs are registered. On sys_rst:
  - state = IDLE.
  - ack, show_char_flag, ascii_num, start_x, start_y, en_size, busy, grant_id = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- IDLE: if init_done && |req, select the first set req bit scanning upward from pointer+1 with wrap-around. Latch its ascii/x/y/size into the outputs and set grant_id. Go to ISSUE.
- ISSUE (1 cycle): show_char_flag = 1, then go to WAIT. Latency is exactly 2 cycles from req sampled in IDLE to flag high.
- WAIT:
  - Hold the latched outputs stable and keep show_char_flag = 0.
  - On show_char_done go to ACK.
  - show_char_done is ignored in IDLE and ISSUE.
- ACK (1 cycle): ack[grant_id] = 1, pointer = grant_id, then return to IDLE.
- Requester rule: data stays stable while req is high. The requester deasserts req or presents the next job on the edge where it samples ack = 1. Because IDLE follows ACK, no double grant is possible.
- Dropping req after grant has no effect; the job completes and ack still pulses.
- Simultaneous requests: round-robin only. Over any window with all requesters continuously active, each requester receives exactly one grant per NUM_REQ grants.
- init_done falling in ISSUE/WAIT/ACK: abort to IDLE next cycle, no ack. Outputs ascii_num/start_x/start_y/en_size cleared to 0 and pointer unchanged.
- sys_rst mid-job: full reset as above, no ack. The engine is assumed to be reset by the same signal.
- Out-of-range req bits (index ≥ NUM_REQ) are not present by construction.

Optional Feature:
- Macro LCD_CHAR_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in WAIT.
  - On reaching TIMEOUT_CYC without show_char_done, go to ACK anyway.
  - Extra output port timeout_err (1 bit, reset 0) pulses together with that ack.
  - The counter clears on entering WAIT.
- When undefined: WAIT waits indefinitely, with no counter and no timeout_err port.

Decomposition:
- Shared package lcd_char_pkg:
  - ASCII_W = 7, COORD_W = 9.
  - ASCII_OFFSET = 32.
  - Font-size constants FONT_16X8 = 1, FONT_12X6 = 0.
  - State enum {IDLE, ISSUE, WAIT, ACK}.
- One natural sub-module, lcd_rr_arbiter: combinational masked-priority select from req and pointer, producing a one-hot grant and a grant index.

Test Plan:
1. Reset, init_done = 1, req = 01, ascii 40, x 128, y 16, size 1 → flag at cycle +2 with outputs 40/128/16/1. Engine done after 10 cycles → ack = 01 for 1 cycle, busy falls.
2. req = 11 held continuously, requesters re-present on each ack → grant order 0, 1, 0, 1; ack alternates 01, 10.
3. init_done = 0 with req = 01 → no flag for 50 cycles. Raising init_done → flag 2 cycles later.
4. init_done drops during WAIT → IDLE next cycle, no ack, outputs 0. Re-raising init_done regrants the same requester.
5. With LCD_CHAR_ARB_TIMEOUT_EN and TIMEOUT_CYC = 20, engine never signals done → ack and timeout_err pulse 20 cycles after WAIT entry.
6. show_char_done pulsed in IDLE → ignored; no ack, state stays IDLE.
